// File: rtl/sqrt_fix_core_pkg.sv
// Shared constants for the fixed-point square-root core: default operand format,
// FSM state encoding and the root-width helper.
package sqrt_fix_core_pkg;

   localparam int DEF_BIT_WIDTH = 32;
   localparam int DEF_FRAC_BITS = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Number of root bits produced for a given fixed-point format.
   function automatic int root_width(input int bit_width, input int frac_bits);
      return (bit_width + frac_bits) / 2;
   endfunction

endpackage

// File: rtl/sqrt_fix_step.sv
// One restoring square-root recurrence step: brings down the next radicand bit pair,
// tries subtracting (4*root + 1) and appends the resulting root bit.
module sqrt_fix_step
   import sqrt_fix_core_pkg::*;
#(
   parameter int ROOT_W = root_width(DEF_BIT_WIDTH, DEF_FRAC_BITS)
)
(
   input  logic [ROOT_W+1:0] i_rem,
   input  logic [ROOT_W-1:0] i_root,
   input  logic [1:0]        i_pair,
   output logic [ROOT_W+1:0] o_rem,
   output logic [ROOT_W-1:0] o_root
);

   localparam int REM_W = ROOT_W + 2;

   logic [REM_W+1:0] w_rem_sh;
   logic [REM_W+1:0] w_trial;
   logic             w_fits;

   // Trial subtraction; the remainder never exceeds 2*root so REM_W bits always hold it.
   always_comb begin
      w_rem_sh = {i_rem, i_pair};
      w_trial  = {2'b00, i_root, 2'b01};
      w_fits   = (w_rem_sh >= w_trial);
      if (w_fits) begin
         o_rem  = REM_W'(w_rem_sh - w_trial);
         o_root = {i_root[ROOT_W-2:0], 1'b1};
      end else begin
         o_rem  = REM_W'(w_rem_sh);
         o_root = {i_root[ROOT_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/sqrt_fix_core.sv
// Fixed-point square root with an ap_ctrl_hs responder interface; one root bit per
// CALC cycle, MSB first, result registered on entry to DONE.
module sqrt_fix_core
   import sqrt_fix_core_pkg::*;
#(
   parameter int BIT_WIDTH = DEF_BIT_WIDTH,
   parameter int FRAC_BITS = DEF_FRAC_BITS
)
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ap_start,
   input  logic signed [BIT_WIDTH-1:0] in_r,
   output logic                        ap_idle,
   output logic                        ap_done,
   output logic                        ap_ready,
   output logic        [BIT_WIDTH-1:0] ap_return
);

   localparam int RAD_W  = BIT_WIDTH + FRAC_BITS;
   localparam int ROOT_W = root_width(BIT_WIDTH, FRAC_BITS);
   localparam int REM_W  = ROOT_W + 2;
   localparam int CNT_W  = $clog2(ROOT_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROOT_W - 1);

   logic [1:0]           r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [RAD_W-1:0]     r_rad;
   logic [REM_W-1:0]     r_rem;
   logic [ROOT_W-1:0]    r_root;
   logic                 r_idle;
   logic                 r_done;
   logic [BIT_WIDTH-1:0] r_return;

   logic [1:0]           w_state_nxt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [RAD_W-1:0]     w_rad_nxt;
   logic [REM_W-1:0]     w_rem_nxt;
   logic [ROOT_W-1:0]    w_root_nxt;
   logic                 w_idle_nxt;
   logic                 w_done_nxt;
   logic [BIT_WIDTH-1:0] w_return_nxt;
   logic [REM_W-1:0]     w_step_rem;
   logic [ROOT_W-1:0]    w_step_root;
   logic [BIT_WIDTH-1:0] w_root_ext;

   sqrt_fix_step #(
      .ROOT_W (ROOT_W)
   ) u_step (
      .i_rem  (r_rem),
      .i_root (r_root),
      .i_pair (r_rad[RAD_W-1:RAD_W-2]),
      .o_rem  (w_step_rem),
      .o_root (w_step_root)
   );

   // Zero-extend the final root into the result format.
   always_comb begin
      w_root_ext = {BIT_WIDTH{1'b0}};
      w_root_ext[ROOT_W-1:0] = w_step_root;
   end

   // Next-state logic; negative operands run the same schedule on a zero radicand.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rad_nxt    = r_rad;
      w_rem_nxt    = r_rem;
      w_root_nxt   = r_root;
      w_return_nxt = r_return;
      w_done_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (ap_start) begin
               w_state_nxt = ST_CALC;
               w_cnt_nxt   = CNT_LOAD;
               w_rem_nxt   = {REM_W{1'b0}};
               w_root_nxt  = {ROOT_W{1'b0}};
               if (in_r[BIT_WIDTH-1]) begin
                  w_rad_nxt = {RAD_W{1'b0}};
               end else begin
                  w_rad_nxt = {in_r, {FRAC_BITS{1'b0}}};
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_CALC: begin
            w_rad_nxt  = {r_rad[RAD_W-3:0], 2'b00};
            w_rem_nxt  = w_step_rem;
            w_root_nxt = w_step_root;
            if (r_cnt == {CNT_W{1'b0}}) begin
               w_state_nxt  = ST_DONE;
               w_done_nxt   = 1'b1;
               w_return_nxt = w_root_ext;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_idle_nxt = (w_state_nxt == ST_IDLE);
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= {CNT_W{1'b0}};
         r_rad    <= {RAD_W{1'b0}};
         r_rem    <= {REM_W{1'b0}};
         r_root   <= {ROOT_W{1'b0}};
         r_idle   <= 1'b1;
         r_done   <= 1'b0;
         r_return <= {BIT_WIDTH{1'b0}};
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rad    <= w_rad_nxt;
         r_rem    <= w_rem_nxt;
         r_root   <= w_root_nxt;
         r_idle   <= w_idle_nxt;
         r_done   <= w_done_nxt;
         r_return <= w_return_nxt;
      end
   end

   assign ap_idle   = r_idle;
   assign ap_done   = r_done;
   assign ap_ready  = r_done;
   assign ap_return = r_return;

endmodule

// File: tb/tb_sqrt_fix_core.sv
// Directed and streaming bench for sqrt_fix_core with a result scoreboard and
// an independent binary-search square-root model.
module tb_sqrt_fix_core;

   typedef struct {
      logic [31:0] exp;
      int          t;
   } sb_t;

   logic        clk;
   logic        reset;
   logic        ap_start;
   logic [31:0] in_r;
   logic        ap_idle;
   logic        ap_done;
   logic        ap_ready;
   logic [31:0] ap_return;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [31:0] last_exp = 32'h0;
   sb_t         sb_q[$];

   sqrt_fix_core #(
      .BIT_WIDTH (32),
      .FRAC_BITS (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ap_start  (ap_start),
      .in_r      (in_r),
      .ap_idle   (ap_idle),
      .ap_done   (ap_done),
      .ap_ready  (ap_ready),
      .ap_return (ap_return)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model_sqrt(input logic [31:0] x);
      longint unsigned rad, lo, hi, mid;
      if (x[31]) return 32'h0;
      rad = {16'h0, x, 16'h0};
      lo  = 64'd0;
      hi  = 64'd1 << 24;
      while (hi - lo > 64'd1) begin
         mid = (lo + hi) >> 1;
         if (mid * mid <= rad) lo = mid;
         else hi = mid;
      end
      return lo[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] exp);
      sb_t e;
      e.exp = exp;
      e.t   = cyc;
      sb_q.push_back(e);
      last_exp = exp;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while (sb_q.size() != 0 && i < 200) begin
         @(posedge clk);
         i++;
      end
      chk("drain_timeout", 32'(sb_q.size()), 32'h0);
      #1;
   endtask

   task automatic run_op(input logic [31:0] x, input logic [31:0] exp);
      wait_drain();
      chk("return_hold", ap_return, last_exp);
      chk("idle_before", {31'b0, ap_idle}, 32'h1);
      ap_start = 1'b1;
      in_r     = x;
      push(exp);
      @(posedge clk);
      #1;
      ap_start = 1'b0;
      in_r     = $urandom;
      chk("idle_in_calc", {31'b0, ap_idle}, 32'h0);
   endtask

   // Result monitor: every completion pulse pops one expected result and its issue time.
   always @(negedge clk) begin : mon
      sb_t e;
      if (ap_done || ap_ready) begin
         chk("ready_eq_done", {31'b0, ap_ready}, {31'b0, ap_done});
         n_checks++;
         assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_done observed=%h expected=no_result", ap_return);
         end
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("ap_return", ap_return, e.exp);
            chk("done_latency", 32'(cyc - e.t), 32'd25);
         end
      end
   end

   initial begin
      reset    = 1'b1;
      ap_start = 1'b0;
      in_r     = 32'h0;
      #1;
      reset = 1'b0;
      #2;
      chk("rst_idle", {31'b0, ap_idle}, 32'h1);
      chk("rst_done", {31'b0, ap_done}, 32'h0);
      chk("rst_ready", {31'b0, ap_ready}, 32'h0);
      chk("rst_return", ap_return, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      run_op(32'h0004_0000, 32'h0002_0000);
      repeat (26) @(posedge clk);
      #1;
      chk("single_pulse", {31'b0, ap_done}, 32'h0);
      run_op(32'h0002_0000, 32'h0001_6A09);
      run_op(32'h0001_0000, 32'h0001_0000);
      run_op(32'h0000_0000, 32'h0000_0000);
      run_op(32'h7FFF_FFFF, 32'h00B5_04F3);
      run_op(32'hFFFF_0000, 32'h0000_0000);
      run_op(32'h0000_0001, 32'h0000_0100);

      // Streaming: start held high, operand changes every cycle.
      wait_drain();
      ap_start = 1'b1;
      for (int i = 0; i < 26 * 4; i++) begin
         in_r = $urandom;
         chk("stream_idle", {31'b0, ap_idle}, (i % 26 == 0) ? 32'h1 : 32'h0);
         if (i % 26 == 0) push(model_sqrt(in_r));
         @(posedge clk);
         #1;
      end
      ap_start = 1'b0;

      // Reset in the middle of CALC aborts without a completion pulse.
      run_op(32'h0004_0000, 32'h0002_0000);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b0;
      sb_q.delete();
      last_exp = 32'h0;
      #2;
      chk("abort_idle", {31'b0, ap_idle}, 32'h1);
      chk("abort_done", {31'b0, ap_done}, 32'h0);
      chk("abort_return", ap_return, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("post_abort_idle", {31'b0, ap_idle}, 32'h1);
      run_op(32'h0009_0000, 32'h0003_0000);
      wait_drain();
      chk("final_return", ap_return, 32'h0003_0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sqrt_fix_core.md
SQRT_FIX_CORE -- requirements
Module: sqrt_fix_core

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: operand and result width.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fractional bits of the fixed-point format; BIT_WIDTH+FRAC_BITS SHALL be even.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (asserted when 0).
REQ-005 SHALL have port ap_start, input, 1: level request; an operation is accepted on a clk edge where ap_start=1 and ap_idle=1.
REQ-006 SHALL have port in_r, input, BIT_WIDTH, signed: radicand, Q(BIT_WIDTH-FRAC_BITS).FRAC_BITS; sampled only on the accepting edge.
REQ-007 SHALL have port ap_idle, output, 1: high while in IDLE.
REQ-008 SHALL have port ap_done, output, 1: one-cycle pulse marking result completion.
REQ-009 SHALL have port ap_ready, output, 1: one-cycle pulse, identical timing to ap_done.
REQ-010 SHALL have port ap_return, output, BIT_WIDTH: square root in the same Q format as in_r.

Function
REQ-011 SHALL be the responder side of the ap_ctrl_hs handshake: the caller drives ap_start and in_r; this block drives ap_idle, ap_done, ap_ready and ap_return.
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on accept; CALC->DONE after the last iteration; DONE->IDLE unconditionally after one cycle.
REQ-013 SHALL form radicand R = in_r zero-extended to BIT_WIDTH+FRAC_BITS bits and shifted left by FRAC_BITS, then compute floor(sqrt(R)) by a restoring digit-by-digit recurrence, one result bit per CALC cycle, MSB first.
REQ-014 SHALL use N = (BIT_WIDTH+FRAC_BITS)/2 CALC cycles (24 at defaults), with an iteration counter loaded with N-1 on accept and leaving CALC when it reaches 0.
REQ-015 SHALL assert ap_done and ap_ready in exactly the one cycle spent in DONE, i.e. the N+1-th cycle after the accepting edge (cycle 25 at defaults).
REQ-016 SHALL update ap_return on the edge entering DONE; the N-bit root is zero-extended to BIT_WIDTH; the value SHALL hold until the next DONE.
REQ-017 SHALL return 0 for a negative in_r (MSB=1), with the same latency and handshake as a valid operand.
REQ-018 SHALL ignore ap_start and in_r while in CALC or DONE; no queueing.
REQ-019 SHALL, when ap_start stays high through DONE, accept the next operation on the first IDLE edge (back-to-back throughput one result per N+2 cycles).
REQ-020 SHALL hold ap_idle=0 in CALC and DONE.

Reset
REQ-021 SHALL, while reset=0, force state IDLE, ap_idle=1, ap_done=0, ap_ready=0, ap_return=0, counter and partial remainder/root=0.
REQ-022 SHALL, on reset assertion mid-CALC, abort the operation with no ap_done pulse; the first accept after deassertion starts a fresh operation.

Structure
REQ-023 SHALL place the FSM state encoding and default BIT_WIDTH/FRAC_BITS constants in the shared SIMD package.
REQ-024 SHALL instantiate one combinational sub-module sqrt_fix_step (one recurrence step: remainder, root in -> remainder, root out); no other sub-modules.
REQ-025 SHALL port-match the existing sqrt_fix usage within the calculus unit so it drops in without caller changes other than driving ap_start.

Verification
REQ-026 SHALL cover: in_r=0x00040000 (4.0), ap_start one cycle -> ap_done/ap_ready single pulse on cycle 25, ap_return=0x00020000.
REQ-027 SHALL cover: in_r=0x00020000 (2.0) -> ap_return=0x00016A09; in_r=0x00010000 -> 0x00010000; in_r=0 -> 0.
REQ-028 SHALL cover: in_r=0x7FFFFFFF -> ap_return=0x00B504F3; in_r=0xFFFF0000 (negative) -> 0x00000000 at cycle 25.
REQ-029 SHALL cover: ap_start held high with in_r changing every cycle -> operands sampled only in IDLE, results every 26 cycles, each matching its sampled operand.
REQ-030 SHALL cover: reset pulsed low at cycle 10 of an operation -> no ap_done, ap_idle=1, ap_return=0; the next operation in_r=0x00090000 -> 0x00030000.
